// File: rtl/button_ctrl.sv
// Pushbutton front end: synchronises and debounces a raw pin, classifies short and long presses,
// and maintains the main_program run-enable level that gates the LED blinker.
//   short press -> toggles main_program on the debounced release
//   long press  -> forces main_program to 0 when the long threshold is reached
module button_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned LONG_CYCLES     = 50_000_000,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic main_program
);

   typedef enum logic [2:0] {
      StIdle,
      StDebPress,
      StHeld,
      StLongHeld,
      StDebRelease
   } state_e;

   // Pin level when the button is not pressed; the synchroniser resets to it.
   localparam logic PinIdle = BTN_ACTIVE_LOW;

   localparam logic [31:0] DebLast  = 32'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0] LongLast = 32'(LONG_CYCLES - 1);
   localparam logic [31:0] CntMax   = '1;

   logic        sync1_d, sync1_q;
   logic        sync2_d, sync2_q;
   logic        btn_s;
   state_e      state_d, state_q;
   logic [31:0] cnt_d, cnt_q;
   logic        long_flag_d, long_flag_q;
   logic        pressed_d, pressed_q;
   logic        press_pulse_d, press_pulse_q;
   logic        release_pulse_d, release_pulse_q;
   logic        long_pulse_d, long_pulse_q;
   logic        main_program_d, main_program_q;

   // Two-flop synchroniser input path and polarity normalisation (btn_s = 1 means pressed).
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      btn_s   = sync2_q ^ PinIdle;
   end

   // Press/release classification; every output is computed here and registered below.
   always_comb begin
      state_d         = state_q;
      long_flag_d     = long_flag_q;
      main_program_d  = main_program_q;
      press_pulse_d   = 1'b0;
      release_pulse_d = 1'b0;
      long_pulse_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (btn_s) begin
               state_d = StDebPress;
            end
         end
         StDebPress: begin
            // A reversal wins over the terminal count: a glitch never produces a pulse.
            if (!btn_s) begin
               state_d = StIdle;
            end else if (cnt_q == DebLast) begin
               state_d       = StHeld;
               press_pulse_d = 1'b1;
               long_flag_d   = 1'b0;
            end
         end
         StHeld: begin
            // Release wins over a long threshold hit in the same cycle.
            if (!btn_s) begin
               state_d = StDebRelease;
            end else if (cnt_q == LongLast) begin
               state_d        = StLongHeld;
               long_pulse_d   = 1'b1;
               long_flag_d    = 1'b1;
               main_program_d = 1'b0;
            end
         end
         StLongHeld: begin
            if (!btn_s) begin
               state_d = StDebRelease;
            end
         end
         StDebRelease: begin
            // Release bounce returns to the held state that was left; HELD restarts its count.
            if (btn_s) begin
               state_d = long_flag_q ? StLongHeld : StHeld;
            end else if (cnt_q == DebLast) begin
               state_d         = StIdle;
               release_pulse_d = 1'b1;
               if (!long_flag_q) begin
                  main_program_d = ~main_program_q;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      pressed_d = (state_d == StHeld) || (state_d == StLongHeld) || (state_d == StDebRelease);
   end

   // Dwell counter: cleared on any state change, otherwise counts up and saturates.
   always_comb begin
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + 32'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State, counter, synchroniser and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q         <= PinIdle;
         sync2_q         <= PinIdle;
         state_q         <= StIdle;
         cnt_q           <= '0;
         long_flag_q     <= 1'b0;
         pressed_q       <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         long_pulse_q    <= 1'b0;
         main_program_q  <= 1'b0;
      end else begin
         sync1_q         <= sync1_d;
         sync2_q         <= sync2_d;
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         long_flag_q     <= long_flag_d;
         pressed_q       <= pressed_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         long_pulse_q    <= long_pulse_d;
         main_program_q  <= main_program_d;
      end
   end

   assign pressed       = pressed_q;
   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;
   assign long_pulse    = long_pulse_q;
   assign main_program  = main_program_q;

endmodule
